// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO controller.
// Read-mode encodings and depth derivation used by the controller and its RAM.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Write/read handshake bundle of the single-clock FIFO.
// The master side is the producer/consumer logic; the slave side is the FIFO.
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);

    logic                  clr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  full;
    logic                  almost_full;
    logic                  wr_overflow;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_en;
    logic                  empty;
    logic                  almost_empty;
    logic                  rd_underflow;
    logic [ADDR_WIDTH:0]   data_count;

    modport master (
        output clr, wr_data, wr_en, rd_en,
        input  full, almost_full, wr_overflow, rd_data,
               empty, almost_empty, rd_underflow, data_count
    );

    modport slave (
        input  clr, wr_data, wr_en, rd_en,
        output full, almost_full, wr_overflow, rd_data,
               empty, almost_empty, rd_underflow, data_count
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Distributed-RAM storage for the FIFO: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: wrap-bit pointers, registered flags and count,
// overflow/underflow pulses, synchronous flush, standard or FWFT read port.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 4,
    parameter int FWFT             = FIFO_MODE_STD,
    parameter int ALMOST_FULL_NUM  = 11,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_fifo_ctrl_if.slave     fifo
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    if (ALMOST_FULL_NUM > DEPTH || ALMOST_FULL_NUM < 1 ||
        ALMOST_EMPTY_NUM >= DEPTH || ALMOST_EMPTY_NUM < 0 ||
        (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)) begin : g_param_err
        $error("sync_fifo_ctrl: illegal FWFT or almost-full/almost-empty threshold");
    end

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t AF_LVL  = ptr_t'(ALMOST_FULL_NUM);
    localparam ptr_t AE_LVL  = ptr_t'(ALMOST_EMPTY_NUM);

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t count_q,  count_d;

    logic full_q,  full_d;
    logic empty_q, empty_d;
    logic afull_q, afull_d;
    logic aempty_q, aempty_d;
    logic ovf_q,   ovf_d;
    logic unf_q,   unf_d;

    logic wr_acc;
    logic rd_acc;

    logic [DATA_WIDTH-1:0] ram_rdata;

    // Acceptance looks only at registered flags; flush wins over both requests.
    always_comb begin
        wr_acc   = fifo.wr_en & ~full_q  & ~fifo.clr;
        rd_acc   = fifo.rd_en & ~empty_q & ~fifo.clr;
        ovf_d    = fifo.wr_en &  full_q  & ~fifo.clr;
        unf_d    = fifo.rd_en &  empty_q & ~fifo.clr;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end

        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                   (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
        afull_d  = (count_d >= AF_LVL);
        aempty_d = (count_d <= AE_LVL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (fifo.wr_data),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented straight from the RAM; meaningless while empty.
        assign fifo.rd_data = ram_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
            end else if (rd_acc) begin
                rd_data_q <= ram_rdata;
            end
        end

        assign fifo.rd_data = rd_data_q;
    end

    assign fifo.full         = full_q;
    assign fifo.almost_full  = afull_q;
    assign fifo.wr_overflow  = ovf_q;
    assign fifo.empty        = empty_q;
    assign fifo.almost_empty = aempty_q;
    assign fifo.rd_underflow = unf_q;
    assign fifo.data_count   = count_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: standard and FWFT instances driven in lockstep,
// table vectors, directed corner sequences and random traffic against a queue model.
module tb_sync_fifo_ctrl;
    import sync_fifo_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 11;
    localparam int AE    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_std ();
    sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_fw ();

    sync_fifo_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_MODE_STD),
        .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
    ) u_std (.clk(clk), .rst_n(rst_n), .fifo(if_std.slave));

    sync_fifo_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_MODE_FWFT),
        .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
    ) u_fw (.clk(clk), .rst_n(rst_n), .fifo(if_fw.slave));

    int total = 0;
    int bad   = 0;

    // Reference model: contents as a queue plus last popped word and pulses.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_std;
    logic          m_ovf;
    logic          m_unf;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            cnt;
        logic          empty;
        logic          full;
        logic          af;
        logic          ae;
        logic          ovf;
        logic          unf;
        logic [DW-1:0] rd_std;
        logic [DW-1:0] head;
    } vec_t;

    vec_t tbl[36];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_std = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic rd, input logic clr, input logic [DW-1:0] din);
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit was_full;
            bit was_empty;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_ovf = wr && was_full;
            m_unf = rd && was_empty;
            if (rd && !was_empty) m_rd_std = q.pop_front();
            if (wr && !was_full)  q.push_back(din);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic clr, input logic [DW-1:0] din);
        if_std.wr_en = wr; if_std.rd_en = rd; if_std.clr = clr; if_std.wr_data = din;
        if_fw.wr_en  = wr; if_fw.rd_en  = rd; if_fw.clr  = clr; if_fw.wr_data  = din;
    endtask

    // One clock with the given request; outputs sampled 1 ns after the edge.
    task automatic cycle(input logic wr, input logic rd, input logic clr, input logic [DW-1:0] din);
        drive(wr, rd, clr, din);
        model_step(wr, rd, clr, din);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},  32'(if_std.data_count),   32'(n));
        chk({tag, ".empty"},  32'(if_std.empty),        32'(n == 0));
        chk({tag, ".full"},   32'(if_std.full),         32'(n == DEPTH));
        chk({tag, ".afull"},  32'(if_std.almost_full),  32'(n >= AF));
        chk({tag, ".aempty"}, 32'(if_std.almost_empty), 32'(n <= AE));
        chk({tag, ".ovf"},    32'(if_std.wr_overflow),  32'(m_ovf));
        chk({tag, ".unf"},    32'(if_std.rd_underflow), 32'(m_unf));
        chk({tag, ".rd_std"}, 32'(if_std.rd_data),      32'(m_rd_std));
        chk({tag, ".fw_cnt"}, 32'(if_fw.data_count),    32'(n));
        chk({tag, ".fw_ovf"}, 32'(if_fw.wr_overflow),   32'(m_ovf));
        chk({tag, ".fw_unf"}, 32'(if_fw.rd_underflow),  32'(m_unf));
        if (n > 0) chk({tag, ".fw_head"}, 32'(if_fw.rd_data), 32'(q[0]));
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        // Fill, overflow, drain, underflow with expectations worked out per row.
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{wr: 1'b1, rd: 1'b0, din: DW'(i + 1), cnt: i + 1, empty: 1'b0,
                       full: (i == 15), af: ((i + 1) >= 11), ae: ((i + 1) <= 4),
                       ovf: 1'b0, unf: 1'b0, rd_std: 16'h0000, head: 16'h0001};
        end
        tbl[16] = '{1'b1, 1'b0, 16'hDEAD, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001};
        for (int k = 0; k < 16; k++) begin
            tbl[18 + k] = '{wr: 1'b0, rd: 1'b1, din: 16'h0000, cnt: 15 - k, empty: (k == 15),
                            full: 1'b0, af: ((15 - k) >= 11), ae: ((15 - k) <= 4),
                            ovf: 1'b0, unf: 1'b0, rd_std: DW'(k + 1), head: DW'(k + 2)};
        end
        tbl[34] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000};
        tbl[35] = '{1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000};

        do_reset();

        for (int i = 0; i < 36; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            cycle(tbl[i].wr, tbl[i].rd, 1'b0, tbl[i].din);
            chk({t, ".count"},  32'(if_std.data_count),   32'(tbl[i].cnt));
            chk({t, ".empty"},  32'(if_std.empty),        32'(tbl[i].empty));
            chk({t, ".full"},   32'(if_std.full),         32'(tbl[i].full));
            chk({t, ".afull"},  32'(if_std.almost_full),  32'(tbl[i].af));
            chk({t, ".aempty"}, 32'(if_std.almost_empty), 32'(tbl[i].ae));
            chk({t, ".ovf"},    32'(if_std.wr_overflow),  32'(tbl[i].ovf));
            chk({t, ".unf"},    32'(if_std.rd_underflow), 32'(tbl[i].unf));
            chk({t, ".rd_std"}, 32'(if_std.rd_data),      32'(tbl[i].rd_std));
            chk({t, ".fw_empty"}, 32'(if_fw.empty),       32'(tbl[i].empty));
            if (!tbl[i].empty) chk({t, ".fw_head"}, 32'(if_fw.rd_data), 32'(tbl[i].head));
            $display("vec%0d wr=%0b rd=%0b count=%0d rd_std=%h", i, tbl[i].wr, tbl[i].rd,
                     if_std.data_count, if_std.rd_data);
        end

        // FWFT: first word visible the cycle empty falls, without any rd_en.
        cycle(1'b1, 1'b0, 1'b0, 16'hABCD);
        chk("fwft.empty_fall", 32'(if_fw.empty), 32'd0);
        chk("fwft.head",       32'(if_fw.rd_data), 32'h0000ABCD);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("fwft.empty_rise", 32'(if_fw.empty), 32'd1);
        check_model("fwft");
        $display("fwft single word popped, empty=%0b", if_fw.empty);

        // Simultaneous read and write at full.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, DW'(16'h0100 + i));
        check_model("fill");
        cycle(1'b1, 1'b1, 1'b0, 16'hBEEF);
        chk("rw_full.count",  32'(if_std.data_count),  32'd15);
        chk("rw_full.ovf",    32'(if_std.wr_overflow), 32'd1);
        chk("rw_full.rd_std", 32'(if_std.rd_data),     32'h00000100);
        $display("rw at full: count=%0d ovf=%0b", if_std.data_count, if_std.wr_overflow);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 16'h0000);
            check_model("drain");
        end

        // Simultaneous read and write at empty.
        cycle(1'b1, 1'b1, 1'b0, 16'h0055);
        chk("rw_empty.count", 32'(if_std.data_count),   32'd1);
        chk("rw_empty.unf",   32'(if_std.rd_underflow), 32'd1);
        $display("rw at empty: count=%0d unf=%0b", if_std.data_count, if_std.rd_underflow);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        check_model("pop55");

        // Steady count 7 across pointer wrap: order must be preserved.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, DW'(16'h0200 + i));
        for (int j = 0; j < 40; j++) begin
            cycle(1'b1, 1'b1, 1'b0, DW'(16'h0300 + j));
            chk($sformatf("steady%0d.count", j), 32'(if_std.data_count), 32'd7);
            chk($sformatf("steady%0d.rd", j), 32'(if_std.rd_data),
                (j < 7) ? 32'(16'h0200 + j) : 32'(16'h0300 + j - 7));
            check_model($sformatf("steady%0d", j));
            $display("steady%0d count=%0d rd_std=%h", j, if_std.data_count, if_std.rd_data);
        end

        // Flush at count 9 overrides same-cycle write and read.
        cycle(1'b1, 1'b0, 1'b0, 16'h0401);
        cycle(1'b1, 1'b0, 1'b0, 16'h0402);
        chk("pre_clr.count", 32'(if_std.data_count), 32'd9);
        cycle(1'b1, 1'b1, 1'b1, 16'hFFFF);
        chk("clr.count", 32'(if_std.data_count),   32'd0);
        chk("clr.empty", 32'(if_std.empty),        32'd1);
        chk("clr.ovf",   32'(if_std.wr_overflow),  32'd0);
        chk("clr.unf",   32'(if_std.rd_underflow), 32'd0);
        check_model("clr");
        $display("clr: count=%0d empty=%0b", if_std.data_count, if_std.empty);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, DW'(16'h0500 + i));
        cycle(1'b1, 1'b1, 1'b0, 16'h0600);
        drive(1'b1, 1'b0, 1'b0, 16'h0601);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.count",  32'(if_std.data_count),   32'd0);
        chk("async_rst.empty",  32'(if_std.empty),        32'd1);
        chk("async_rst.aempty", 32'(if_std.almost_empty), 32'd1);
        chk("async_rst.full",   32'(if_std.full),         32'd0);
        chk("async_rst.rd_std", 32'(if_std.rd_data),      32'd0);
        check_model("async_rst");
        $display("async reset: count=%0d empty=%0b", if_std.data_count, if_std.empty);
        drive(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic, write-heavy then read-heavy, rare flushes.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 200; i++) begin
                logic wr, rd, clr;
                logic [DW-1:0] din;
                wr  = ($urandom_range(0, 99) < ((ph == 0) ? 70 : 30));
                rd  = ($urandom_range(0, 99) < ((ph == 0) ? 30 : 70));
                clr = ($urandom_range(0, 99) < 2);
                din = DW'($urandom);
                cycle(wr, rd, clr, din);
                check_model($sformatf("rand%0d_%0d", ph, i));
            end
            $display("random phase %0d end count=%0d", ph, if_std.data_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
